// File: rtl/mux_n1_rr.sv
// mux_n1_rr: registered N:1 valid/ready multiplexer with fixed-select or round-robin channel grant
module mux_n1_rr #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_ch,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [SEL_W-1:0] ptr, rr_g, g;
  logic             rr_hit, fx_hit, hit, load;
  function automatic int wrap(int v);
    return v >= N ? v - N : v;
  endfunction
  // descending scan so the channel closest to ptr overwrites the others
  always_comb begin
    rr_hit = 1'b0;
    rr_g = '0;
    for (int i = N - 1; i >= 0; i--)
      if (in_valid[wrap(int'(ptr) + i)]) begin
        rr_hit = 1'b1;
        rr_g = SEL_W'(wrap(int'(ptr) + i));
      end
  end
  assign fx_hit   = (int'(sel) < N) && in_valid[sel];
  assign hit      = mode ? rr_hit : fx_hit;
  assign g        = mode ? rr_g : sel;
  assign load     = !out_valid || out_ready;
  assign in_ready = (rst_n && load && hit) ? N'(1) << g : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= '0;
    end else if (load) begin
      out_valid <= hit;
      if (hit) begin
        out_data <= in_data[g*W +: W];
        out_ch <= g;
        if (mode) ptr <= (int'(g) == N - 1) ? '0 : g + 1'b1;
      end
    end
endmodule

// File: tb/tb_mux_n1_rr.sv
// tb_mux_n1_rr: randomized checks of mux_n1_rr against a queue-free behavioural model
module tb_mux_n1_rr;
  localparam int N = 4, W = 8, SEL_W = 2;
  logic clk = 0, rst_n = 0, mode = 0, out_ready = 0;
  logic [SEL_W-1:0] sel = 0;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid = 0, in_ready;
  logic [W-1:0] out_data, word [N];
  logic [SEL_W-1:0] out_ch;
  logic out_valid;
  int checks = 0, errors = 0;
  bit m_valid;
  int m_data, m_ch, m_ptr;

  mux_n1_rr #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;
  always_comb for (int k = 0; k < N; k++) in_data[k*W +: W] = word[k];

  function automatic void grant(output bit ok, output int gi);
    ok = 0;
    gi = 0;
    if (!mode) begin
      if (int'(sel) < N && in_valid[sel]) begin ok = 1; gi = int'(sel); end
    end else
      for (int k = 0; k < N; k++)
        if (!ok && in_valid[(m_ptr + k) % N]) begin ok = 1; gi = (m_ptr + k) % N; end
  endfunction

  function automatic logic [N-1:0] exp_ready();
    bit ok;
    int gi;
    grant(ok, gi);
    return (rst_n && ok && (!m_valid || out_ready)) ? 4'(1 << gi) : 4'b0;
  endfunction

  function automatic void model_reset();
    m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
  endfunction

  task automatic tick();
    bit ok;
    int gi;
    bit ld;
    grant(ok, gi);
    ld = !m_valid || out_ready;
    @(posedge clk);
    if (ld) begin
      m_valid = ok;
      if (ok) begin
        m_data = int'(word[gi]);
        m_ch = gi;
        if (mode) m_ptr = (gi + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    mode = 1; in_valid = 4'hF; out_ready = 1;
    #1;
    checks++;
    if (out_valid !== 0 || out_data !== 0 || out_ch !== 0) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h ch=%0d, want 0/00/0", out_valid, out_data, out_ch);
    end
    checks++;
    if (in_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, want 0000", in_ready);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_fixed();
    mode = 0; sel = 2; in_valid = 4'hF; out_ready = 1;
    word[0] = 8'h01; word[1] = 8'h02; word[2] = 8'hA5; word[3] = 8'h04;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL fixed_ready: in_ready=%b, want 0100", in_ready);
    end
    tick();
    checks++;
    if (out_data !== 8'hA5 || out_ch !== 2 || out_valid !== 1) begin
      errors++;
      $display("FAIL fixed_out: data=%h ch=%0d valid=%b, want a5/2/1", out_data, out_ch, out_valid);
    end
    for (int c = 0; c < 30; c++) begin
      sel = SEL_W'($urandom_range(0, N - 1));
      in_valid = N'($urandom);
      out_ready = 1'($urandom);
      for (int k = 0; k < N; k++) word[k] = W'($urandom);
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        errors++;
        $display("FAIL fixed_rand_ready: in_ready=%b, want %b", in_ready, exp_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_valid || (m_valid && (int'(out_data) != m_data || int'(out_ch) != m_ch))) begin
        errors++;
        $display("FAIL fixed_rand_out: valid=%b data=%h ch=%0d, want %b/%h/%0d", out_valid, out_data, out_ch, m_valid, m_data, m_ch);
      end
    end
  endtask

  task automatic test_rr_all();
    int exp_ch [6] = '{0, 1, 2, 3, 0, 1};
    mode = 1; in_valid = 4'hF; out_ready = 1;
    for (int k = 0; k < N; k++) word[k] = W'(8'h10 + k);
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (out_valid !== 1 || int'(out_ch) != exp_ch[c] || int'(out_data) != 8'h10 + exp_ch[c]) begin
        errors++;
        $display("FAIL rr_all[%0d]: valid=%b ch=%0d data=%h, want 1/%0d/%h", c, out_valid, out_ch, out_data, exp_ch[c], 8'h10 + exp_ch[c]);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int prev = -1;
    mode = 1; in_valid = 4'b1010; out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (in_ready[0] !== 0 || in_ready[2] !== 0 || in_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rr_sparse_ready[%0d]: in_ready=%b, want %b", c, in_ready, exp_ready());
      end
      tick();
      checks++;
      if (out_valid !== 1 || (out_ch != 1 && out_ch != 3) || int'(out_ch) == prev || int'(out_ch) != m_ch) begin
        errors++;
        $display("FAIL rr_sparse_ch[%0d]: ch=%0d prev=%0d valid=%b, want %0d", c, out_ch, prev, out_valid, m_ch);
      end
      prev = int'(out_ch);
    end
  endtask

  task automatic test_backpressure();
    mode = 0; sel = 0; in_valid = 4'b0001; out_ready = 1; word[0] = 8'h33;
    tick();
    checks++;
    if (out_data !== 8'h33 || out_valid !== 1) begin
      errors++;
      $display("FAIL bp_load: data=%h valid=%b, want 33/1", out_data, out_valid);
    end
    out_ready = 0; word[0] = 8'h44;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d]: in_ready=%b, want 0000", c, in_ready);
      end
      tick();
      checks++;
      if (out_data !== 8'h33 || out_valid !== 1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: data=%h valid=%b, want 33/1", c, out_data, out_valid);
      end
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release_ready: in_ready=%b, want 0001", in_ready);
    end
    tick();
    checks++;
    if (out_data !== 8'h44 || out_valid !== 1) begin
      errors++;
      $display("FAIL bp_release: data=%h valid=%b, want 44/1", out_data, out_valid);
    end
  endtask

  task automatic test_fixed_invalid();
    mode = 0; sel = 1; in_valid = 4'b1101; out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 4'b0) begin
      errors++;
      $display("FAIL finv_ready: in_ready=%b, want 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 0) begin
      errors++;
      $display("FAIL finv_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      mode = 1'($urandom);
      sel = SEL_W'($urandom);
      in_valid = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) word[k] = W'($urandom);
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rand_ready[%0d]: in_ready=%b, want %b", c, in_ready, exp_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_valid || (m_valid && (int'(out_data) != m_data || int'(out_ch) != m_ch))) begin
        errors++;
        $display("FAIL rand_out[%0d]: valid=%b data=%h ch=%0d, want %b/%h/%0d", c, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1; in_valid = 4'hF; out_ready = 1;
    for (int k = 0; k < N; k++) word[k] = W'(8'h50 + k);
    tick();
    tick();
    out_ready = 0;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 0 || out_data !== 0 || in_ready !== 4'b0) begin
      errors++;
      $display("FAIL rmid_async: valid=%b data=%h in_ready=%b, want 0/00/0000", out_valid, out_data, in_ready);
    end
    @(negedge clk);
    rst_n = 1; out_ready = 1;
    tick();
    checks++;
    if (out_valid !== 1 || out_ch !== 0 || out_data !== 8'h50) begin
      errors++;
      $display("FAIL rmid_first: valid=%b ch=%0d data=%h, want 1/0/50", out_valid, out_ch, out_data);
    end
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < N; k++) word[k] = '0;
    @(negedge clk);
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_fixed_invalid();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
